// File: rtl/johnson_phase_decoder.sv
// Johnson counter phase decoder: one-hot/binary phase decode, step legality check,
// lock tracking and a saturating error counter. All outputs registered.
module johnson_phase_decoder #(
    parameter int WIDTH     = 4,
    parameter int LOCK_CNT  = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                          Clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              q_in,
    input  logic                          clr_err,
    output logic [2*WIDTH-1:0]            phase,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic                          valid_code,
    output logic                          step_err,
    output logic                          locked,
    output logic [ERR_CNT_W-1:0]          err_count
);

    localparam int PH    = 2 * WIDTH;
    localparam int IDX_W = $clog2(PH);
    localparam int ADV_W = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PH - 1);
    localparam logic [ADV_W-1:0] LOCK_TGT = ADV_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } dec_t;

    state_t state, state_nx;

    logic [PH-1:0][WIDTH-1:0] code_tbl;
    logic [PH-1:0]            hit;
    dec_t                     dec;

    logic [IDX_W-1:0] prev_idx, prev_nx, prev_succ;
    logic [ADV_W-1:0] adv_cnt, adv_nx, adv_inc;
    logic             is_hold, is_adv, is_jump;
    logic             step_err_nx;
    logic [ERR_CNT_W-1:0] err_nx;

    // Phases 0..WIDTH fill ones from the LSB; the rest fill from the MSB.
    for (genvar p = 0; p < PH; p++) begin : g_code
        if (p <= WIDTH) begin : g_lsb
            assign code_tbl[p] = ONES >> (WIDTH - p);
        end else begin : g_msb
            assign code_tbl[p] = ~(ONES >> (PH - p));
        end
        assign hit[p] = (q_in == code_tbl[p]);
    end

    // Codes are distinct, so hit is one-hot or zero and an OR-encode is exact.
    always_comb begin
        dec       = '0;
        dec.valid = |hit;
        for (int p = 0; p < PH; p++) begin
            if (hit[p]) dec.idx = dec.idx | IDX_W'(p);
        end
    end

    assign prev_succ = (prev_idx == LAST_IDX) ? '0 : prev_idx + 1'b1;
    assign is_hold   = dec.valid && (dec.idx == prev_idx);
    assign is_adv    = dec.valid && (dec.idx == prev_succ);
    assign is_jump   = dec.valid && !is_hold && !is_adv;
    assign adv_inc   = adv_cnt + 1'b1;

    always_ff @(posedge Clk) begin
        if (!rst) state <= UNLOCKED;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            UNLOCKED: if (dec.valid) state_nx = ACQUIRE;
            ACQUIRE: begin
                if (!dec.valid)                        state_nx = UNLOCKED;
                else if (is_adv && adv_inc == LOCK_TGT) state_nx = LOCKED;
            end
            LOCKED:   if (!dec.valid || is_jump) state_nx = UNLOCKED;
            default:  state_nx = UNLOCKED;
        endcase
    end

    always_comb begin
        step_err_nx = 1'b0;
        adv_nx      = adv_cnt;
        prev_nx     = dec.valid ? dec.idx : prev_idx;
        case (state)
            UNLOCKED: begin
                if (dec.valid) adv_nx      = '0;
                else           step_err_nx = 1'b1;
            end
            ACQUIRE: begin
                if (!dec.valid || is_jump) begin
                    step_err_nx = 1'b1;
                    adv_nx      = '0;
                end else if (is_adv) begin
                    adv_nx = adv_inc;
                end
            end
            LOCKED: begin
                if (!dec.valid || is_jump) begin
                    step_err_nx = 1'b1;
                    adv_nx      = '0;
                end
            end
            default: adv_nx = '0;
        endcase
    end

    // Clear takes effect first, so an error in the clearing cycle leaves a count of 1.
    always_comb begin
        err_nx = err_count;
        if (clr_err)                         err_nx = ERR_CNT_W'(step_err_nx);
        else if (step_err_nx && !(&err_count)) err_nx = err_count + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!rst) begin
            prev_idx   <= '0;
            adv_cnt    <= '0;
            phase      <= '0;
            phase_idx  <= '0;
            valid_code <= 1'b0;
            step_err   <= 1'b0;
            locked     <= 1'b0;
            err_count  <= '0;
        end else begin
            prev_idx   <= prev_nx;
            adv_cnt    <= adv_nx;
            phase      <= hit;
            phase_idx  <= dec.idx;
            valid_code <= dec.valid;
            step_err   <= step_err_nx;
            locked     <= (state_nx == LOCKED);
            err_count  <= err_nx;
        end
    end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: decode table, lock/unlock, error count
// saturation and clear, reset mid-lock.
module tb_johnson_phase_decoder;

    logic       Clk = 1'b0;
    logic       rst;
    logic [3:0] q_in;
    logic       clr_err;
    logic [7:0] phase;
    logic [2:0] phase_idx;
    logic       valid_code;
    logic       step_err;
    logic       locked;
    logic [7:0] err_count;

    int n_vec = 0;
    int n_bad = 0;

    johnson_phase_decoder #(.WIDTH(4), .LOCK_CNT(3), .ERR_CNT_W(8)) dut (
        .Clk        (Clk),
        .rst        (rst),
        .q_in       (q_in),
        .clr_err    (clr_err),
        .phase      (phase),
        .phase_idx  (phase_idx),
        .valid_code (valid_code),
        .step_err   (step_err),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] q, input logic c);
        q_in    = q;
        clr_err = c;
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_o(input string tag, input logic [7:0] ph, input logic [2:0] ix,
                            input logic vc, input logic se, input logic lk,
                            input logic [7:0] ec);
        chk({tag, ".phase"},  32'(phase),      32'(ph));
        chk({tag, ".idx"},    32'(phase_idx),  32'(ix));
        chk({tag, ".valid"},  32'(valid_code), 32'(vc));
        chk({tag, ".serr"},   32'(step_err),   32'(se));
        chk({tag, ".locked"}, 32'(locked),     32'(lk));
        chk({tag, ".errcnt"}, 32'(err_count),  32'(ec));
    endtask

    initial begin
        rst     = 1'b0;
        q_in    = 4'b0011;
        clr_err = 1'b0;
        drive(4'b0011, 1'b0);
        drive(4'b0011, 1'b1);
        expect_o("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b1;

        // Acquire and lock on the third advance.
        drive(4'b0000, 1'b0); expect_o("t1.0", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(4'b0001, 1'b0); expect_o("t1.1", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(4'b0011, 1'b0); expect_o("t1.2", 8'h04, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(4'b0111, 1'b0); expect_o("t1.3", 8'h08, 3'd3, 1'b1, 1'b0, 1'b1, 8'd0);

        drive(4'b1111, 1'b0); expect_o("t2.4", 8'h10, 3'd4, 1'b1, 1'b0, 1'b1, 8'd0);
        drive(4'b1110, 1'b0); expect_o("t2.5", 8'h20, 3'd5, 1'b1, 1'b0, 1'b1, 8'd0);
        drive(4'b1100, 1'b0); expect_o("t2.6", 8'h40, 3'd6, 1'b1, 1'b0, 1'b1, 8'd0);
        drive(4'b1000, 1'b0); expect_o("t2.7", 8'h80, 3'd7, 1'b1, 1'b0, 1'b1, 8'd0);
        drive(4'b0000, 1'b0); expect_o("t2.wrap", 8'h01, 3'd0, 1'b1, 1'b0, 1'b1, 8'd0);

        // HOLD keeps lock, JUMP 3 -> 2 drops it.
        drive(4'b0001, 1'b0);
        drive(4'b0011, 1'b0);
        drive(4'b0111, 1'b0); expect_o("t3.adv", 8'h08, 3'd3, 1'b1, 1'b0, 1'b1, 8'd0);
        drive(4'b0111, 1'b0); expect_o("t3.hold", 8'h08, 3'd3, 1'b1, 1'b0, 1'b1, 8'd0);
        drive(4'b0011, 1'b0); expect_o("t3.jump", 8'h04, 3'd2, 1'b1, 1'b1, 1'b0, 8'd1);
        drive(4'b0011, 1'b0); expect_o("t3.after", 8'h04, 3'd2, 1'b1, 1'b0, 1'b0, 8'd1);

        drive(4'b0101, 1'b0); expect_o("t4.inv", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 8'd2);

        // Clear alone with a legal code, then saturate.
        drive(4'b0000, 1'b1); expect_o("t5.clr", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 260; i++) begin
            drive(4'b0101, 1'b0);
            if (i == 252) chk("t5.mid", 32'(err_count), 32'd253);
        end
        expect_o("t5.sat", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 8'd255);
        drive(4'b0101, 1'b1); expect_o("t5.clrerr", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 8'd1);

        // Relock, move to idx 5, then reset mid-lock.
        drive(4'b0000, 1'b0); expect_o("t6.acq", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1);
        drive(4'b0001, 1'b0);
        drive(4'b0011, 1'b0);
        drive(4'b0111, 1'b0); expect_o("t6.lock", 8'h08, 3'd3, 1'b1, 1'b0, 1'b1, 8'd1);
        drive(4'b1111, 1'b0);
        drive(4'b1110, 1'b0); expect_o("t6.idx5", 8'h20, 3'd5, 1'b1, 1'b0, 1'b1, 8'd1);
        rst = 1'b0;
        drive(4'b1100, 1'b0); expect_o("t6.rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b1;
        drive(4'b0000, 1'b0); expect_o("t6.r0", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(4'b0001, 1'b0); expect_o("t6.r1", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(4'b0011, 1'b0); expect_o("t6.r2", 8'h04, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(4'b0111, 1'b0); expect_o("t6.r3", 8'h08, 3'd3, 1'b1, 1'b0, 1'b1, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
